alu_seq: RTL and testbench
==========================

# alu_seq

Sequential, parametrised ALU with valid/ready handshakes on both sides. It executes the full logic/shift/load-immediate set in one cycle, adds an iterative unsigned multiplier (MUL, MULHU), and returns a registered result with a four-flag status. It sits between operand-fetch and write-back in the datapath. Back-pressure is honoured on both ports.

## Interface
- DATA_WIDTH, default ALU_DATA_WIDTH (32): operand/result width; must be even and ≥ 4.
- OP_WIDTH, default ALU_OP_WIDTH (4): opcode width.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/opcode present.
- in_ready  out  1  block can accept an operation.
- in_a  in  DATA_WIDTH  operand a.
- in_b  in  DATA_WIDTH  operand b.
- in_op  in  OP_WIDTH  operation (alu_op_t).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- out_r  out  DATA_WIDTH  result.
- out_flags  out  4  alu_flags_t {z, n, c, v}.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, BUSY (multiply in progress), DONE (result held).
- IDLE:
  - in_ready = 1.
  - On in_valid, latch the operands and opcode.
  - MUL/MULHU go to BUSY with the iteration counter at 0.
  - All other opcodes compute, register out_r/out_flags, and go to DONE.
- BUSY: one shift-add step per cycle. After DATA_WIDTH steps, register the result and flags, then go to DONE.
- DONE:
  - out_valid = 1; out_r and out_flags are held stable.
  - On out_ready, go to IDLE.
- in_ready is 0 in BUSY and DONE. in_valid is ignored there; no operation is queued.
- Opcode results (W = DATA_WIDTH):
  - ADD / SUB / AND / OR / XOR: standard.
  - LUI: {b[W/2-1:0], zeros}.
  - LLI: {zeros, b[W/2-1:0]}.
  - Shifts (SLL, SRL, SLA = SLL, SRA): amount is b[$clog2(W)-1:0]; upper bits of b are ignored. SRA is arithmetic on a.
  - MUL: low W bits of unsigned a*b.
  - MULHU: high W bits of unsigned a*b.
  - Undefined opcode: r = 0, single cycle.
- Flags:
  - z = (r == 0).
  - n = r[W-1].
  - c:
    - ADD: carry-out.
    - SUB: borrow (a < b unsigned).
    - Shifts with amount > 0: last bit shifted out.
    - MUL: high half ≠ 0.
    - Otherwise 0.
  - v:
    - ADD/SUB: signed overflow.
    - MUL: high half ≠ 0.
    - Otherwise 0.
- Arithmetic is internally W+1 bits for carry. The multiplier uses a 2W-bit product register.

## Timing
- Reset values:
  - state IDLE; in_ready 1; out_valid 0; busy 0.
  - out_r 0; out_flags 0; counter 0.
- Latency is measured from the acceptance cycle c (in_valid & in_ready):
  - Single-cycle ops: out_valid high in cycle c+1.
  - MUL/MULHU: out_valid high in cycle c+W+1.
- out_valid stays high, with data stable, until the cycle out_ready = 1. state is IDLE (in_ready = 1) the following cycle.
- Throughput:
  - Single-cycle ops: one op per 2 cycles with out_ready held high.
  - MUL/MULHU: one op per W+2 cycles.
- out_ready while out_valid = 0 has no effect.
- rst has priority in every state:
  - rst mid-BUSY aborts the multiply; no result is emitted.
  - rst in DONE drops out_valid on the next cycle, and the result is lost.
- rst and in_valid in the same cycle: the operation is not accepted.

## Structure
- alu_pkg holds:
  - ALU_DATA_WIDTH.
  - ALU_OP_WIDTH = 4.
  - alu_op_t, extended with MUL and MULHU.
  - alu_flags_t, a packed struct {z, n, c, v}.
  - alu_state_t {IDLE, BUSY, DONE}.
- Sub-module alu_mul_iter:
  - Parameter WIDTH.
  - Ports: clk, rst, start, a, b, done (pulse), prod (2·WIDTH bits).
  - Instantiated once; start is asserted on MUL/MULHU acceptance.
- Top level contains the handshake FSM, the single-cycle datapath, the flag logic and the output registers.

## Test plan
Bench uses DATA_WIDTH = 8.
- ADD a=0x7F, b=0x01 → out_valid in cycle c+1; r=0x80, n=1, v=1, c=0, z=0.
- SUB a=0x00, b=0x01 → r=0xFF, c=1, n=1, v=0. Then AND a=0xF0, b=0x0F → r=0x00, z=1.
- MUL a=0x10, b=0x10 → out_valid in cycle c+9; r=0x00, z=1, c=1, v=1. MULHU with the same operands → r=0x01, c=0, v=0.
- SRA a=0x80, b=0x09 → amount 1; r=0xC0, c=0. SRL a=0x03, b=0x01 → r=0x01, c=1.
- Back-pressure: ADD accepted, out_ready low 5 cycles, with in_valid held high and a different op on in_a/in_b/in_op → out_r/out_flags stable and in_ready = 0 throughout. On the out_ready cycle, the next cycle has in_ready = 1; the pending op is accepted only then.
- rst asserted in the 4th BUSY cycle of a MUL → out_valid never asserts. Next cycle: in_ready = 1, busy = 0, out_r = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and defaults for the sequential ALU: opcodes, status flags
// and handshake FSM states.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 32;
  localparam int ALU_OP_WIDTH   = 4;

  // Encodings 13..15 are left undefined and produce a zero result.
  typedef enum logic [ALU_OP_WIDTH-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_LUI   = 4'd5,
    OP_LLI   = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SLA   = 4'd9,
    OP_SRA   = 4'd10,
    OP_MUL   = 4'd11,
    OP_MULHU = 4'd12
  } alu_op_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle,
// WIDTH steps after start; done pulses in the cycle of the final step.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               r_active;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_accNext;
  logic               w_last;

  // Low half of the accumulator holds the remaining multiplier bits; each step
  // adds the multiplicand into the high half and shifts the whole thing right.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_accNext = {w_sum, r_acc[WIDTH-1:1]};
  assign w_last    = r_active && (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_count  <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
    end else if (start) begin
      r_active <= 1'b1;
      r_count  <= '0;
      r_mcand  <= a;
      r_acc    <= {{WIDTH{1'b0}}, b};
    end else if (r_active) begin
      r_acc   <= w_accNext;
      r_count <= r_count + 1'b1;
      if (w_last) begin
        r_active <= 1'b0;
      end
    end
  end

  // The finished product is presented combinationally alongside done.
  assign done = w_last;
  assign prod = w_accNext;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both ports: single-cycle logic/shift/
// arithmetic ops, iterative MUL/MULHU, registered result and {z,n,c,v} flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int OP_WIDTH   = ALU_OP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [OP_WIDTH-1:0]   in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_r,
  output alu_flags_t            out_flags,
  output logic                  busy
);

  localparam int W  = DATA_WIDTH;
  localparam int HW = DATA_WIDTH / 2;
  localparam int SW = $clog2(DATA_WIDTH);

  alu_state_t r_state;
  alu_state_t w_stateNext;
  alu_op_t    r_op;
  logic [W-1:0] r_result;
  alu_flags_t   r_flags;

  alu_op_t      w_op;
  logic         w_isMul;
  logic         w_accept;
  logic [SW-1:0] w_amt;
  logic [W:0]   w_sum;
  logic [W:0]   w_diff;
  logic [W:0]   w_shl;
  logic [W:0]   w_shr;
  logic [W:0]   w_sra;
  logic [W-1:0] w_res;
  logic         w_c;
  logic         w_v;
  alu_flags_t   w_aluFlags;

  logic         w_mulDone;
  logic [2*W-1:0] w_prod;
  logic [W-1:0] w_mulRes;
  logic         w_mulOvf;
  alu_flags_t   w_mulFlags;

  assign w_op     = alu_op_t'(in_op[ALU_OP_WIDTH-1:0]);
  assign w_isMul  = (w_op == OP_MUL) || (w_op == OP_MULHU);
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_amt    = in_b[SW-1:0];

  // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
  assign w_sum  = {1'b0, in_a} + {1'b0, in_b};
  assign w_diff = {1'b0, in_a} - {1'b0, in_b};
  assign w_shl  = {1'b0, in_a} << w_amt;
  assign w_shr  = {in_a, 1'b0} >> w_amt;
  assign w_sra  = $signed({in_a, 1'b0}) >>> w_amt;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (in_a[W-1] == in_b[W-1]) && (w_sum[W-1] != in_a[W-1]);
      end
      OP_SUB: begin
        w_res = w_diff[W-1:0];
        w_c   = w_diff[W];
        w_v   = (in_a[W-1] != in_b[W-1]) && (w_diff[W-1] != in_a[W-1]);
      end
      OP_AND: w_res = in_a & in_b;
      OP_OR:  w_res = in_a | in_b;
      OP_XOR: w_res = in_a ^ in_b;
      OP_LUI: w_res = {in_b[HW-1:0], {(W - HW){1'b0}}};
      OP_LLI: w_res = {{(W - HW){1'b0}}, in_b[HW-1:0]};
      OP_SLL, OP_SLA: begin
        w_res = w_shl[W-1:0];
        w_c   = w_shl[W];
      end
      OP_SRL: begin
        w_res = w_shr[W:1];
        w_c   = w_shr[0];
      end
      OP_SRA: begin
        w_res = w_sra[W:1];
        w_c   = w_sra[0];
      end
      default: begin
        w_res = '0;
      end
    endcase
  end

  assign w_aluFlags = '{z: (w_res == '0), n: w_res[W-1], c: w_c, v: w_v};

  alu_mul_iter #(
    .WIDTH (W)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (w_accept && w_isMul),
    .a     (in_a),
    .b     (in_b),
    .done  (w_mulDone),
    .prod  (w_prod)
  );

  assign w_mulRes   = (r_op == OP_MULHU) ? w_prod[2*W-1:W] : w_prod[W-1:0];
  assign w_mulOvf   = (r_op == OP_MUL) && (w_prod[2*W-1:W] != '0);
  assign w_mulFlags = '{z: (w_mulRes == '0), n: w_mulRes[W-1], c: w_mulOvf, v: w_mulOvf};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (in_valid)  w_stateNext = w_isMul ? BUSY : DONE;
      BUSY: if (w_mulDone) w_stateNext = DONE;
      DONE: if (out_ready) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Result registers load on single-cycle acceptance or on multiplier completion
  // and otherwise hold, which keeps out_r/out_flags stable while in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= OP_ADD;
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_accept) begin
      r_op <= w_op;
      if (!w_isMul) begin
        r_result <= w_res;
        r_flags  <= w_aluFlags;
      end
    end else if ((r_state == BUSY) && w_mulDone) begin
      r_result <= w_mulRes;
      r_flags  <= w_mulFlags;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_r     = r_result;
  assign out_flags = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at DATA_WIDTH = 8: latency,
// results/flags per opcode, back-pressure and reset abort.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [3:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_r;
  alu_flags_t   out_flags;
  logic         busy;

  int nCompared   = 0;
  int nMismatched = 0;

  alu_seq #(
    .DATA_WIDTH (W),
    .OP_WIDTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_flags (out_flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one op in the current cycle (which must be an accept cycle) and
  // returns one cycle later with in_valid dropped.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    checkOutput("acceptReady", {31'd0, in_ready}, 32'd1);
    stepCycle();
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag, input int expLat, input logic [W-1:0] expR, input logic [3:0] expFlags);
    int lat = 1;
    while (!out_valid && lat < 40) begin
      stepCycle();
      lat++;
    end
    checkOutput({tag, ".lat"}, lat, expLat);
    checkOutput({tag, ".r"}, {24'd0, out_r}, {24'd0, expR});
    checkOutput({tag, ".flags"}, {28'd0, out_flags}, {28'd0, expFlags});
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
    checkOutput({tag, ".readyAfter"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, ".validAfter"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int sawValid;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b0;
    repeat (3) stepCycle();
    rst = 1'b0;

    checkOutput("rst.inReady", {31'd0, in_ready}, 32'd1);
    checkOutput("rst.outValid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst.busy", {31'd0, busy}, 32'd0);
    checkOutput("rst.outR", {24'd0, out_r}, 32'd0);
    checkOutput("rst.flags", {28'd0, out_flags}, 32'd0);

    // Flags are {z, n, c, v}.
    applyStimulus(OP_ADD, 8'h7F, 8'h01);   waitResult("add7f", 1, 8'h80, 4'b0101);
    applyStimulus(OP_SUB, 8'h00, 8'h01);   waitResult("sub", 1, 8'hFF, 4'b0110);
    applyStimulus(OP_AND, 8'hF0, 8'h0F);   waitResult("and", 1, 8'h00, 4'b1000);
    applyStimulus(OP_ADD, 8'hFF, 8'h01);   waitResult("addCarry", 1, 8'h00, 4'b1010);
    applyStimulus(OP_XOR, 8'hFF, 8'h0F);   waitResult("xor", 1, 8'hF0, 4'b0100);
    applyStimulus(OP_OR,  8'h21, 8'h12);   waitResult("or", 1, 8'h33, 4'b0000);
    applyStimulus(OP_LUI, 8'h00, 8'hA5);   waitResult("lui", 1, 8'h50, 4'b0000);
    applyStimulus(OP_LLI, 8'hFF, 8'hA5);   waitResult("lli", 1, 8'h05, 4'b0000);
    applyStimulus(OP_SRA, 8'h80, 8'h09);   waitResult("sra", 1, 8'hC0, 4'b0100);
    applyStimulus(OP_SRL, 8'h03, 8'h01);   waitResult("srl", 1, 8'h01, 4'b0010);
    applyStimulus(OP_SLL, 8'h81, 8'h01);   waitResult("sll", 1, 8'h02, 4'b0010);
    applyStimulus(OP_SLA, 8'h81, 8'h00);   waitResult("slaZero", 1, 8'h81, 4'b0100);
    applyStimulus(4'd15,  8'h12, 8'h34);   waitResult("undef", 1, 8'h00, 4'b1000);

    applyStimulus(OP_MUL, 8'h10, 8'h10);
    checkOutput("mul.busy", {31'd0, busy}, 32'd1);
    checkOutput("mul.inReady", {31'd0, in_ready}, 32'd0);
    waitResult("mul", 9, 8'h00, 4'b1011);
    applyStimulus(OP_MULHU, 8'h10, 8'h10); waitResult("mulhu", 9, 8'h01, 4'b0000);
    applyStimulus(OP_MUL,   8'hFF, 8'hFF); waitResult("mulFF", 9, 8'h01, 4'b0011);
    applyStimulus(OP_MULHU, 8'hFF, 8'hFF); waitResult("mulhuFF", 9, 8'hFE, 4'b0100);

    // Back-pressure with a second op waiting on the input port.
    applyStimulus(OP_ADD, 8'h12, 8'h34);
    in_op    = OP_SUB;
    in_a     = 8'h01;
    in_b     = 8'h02;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp.valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp.r", {24'd0, out_r}, 32'h46);
      checkOutput("bp.flags", {28'd0, out_flags}, 32'd0);
      checkOutput("bp.inReady", {31'd0, in_ready}, 32'd0);
      stepCycle();
    end
    out_ready = 1'b1;
    checkOutput("bp.rRelease", {24'd0, out_r}, 32'h46);
    stepCycle();
    out_ready = 1'b0;
    checkOutput("bp.inReadyNext", {31'd0, in_ready}, 32'd1);
    stepCycle();
    in_valid = 1'b0;
    waitResult("bpPending", 1, 8'hFF, 4'b0110);

    // Reset in the 4th BUSY cycle of a multiply.
    applyStimulus(OP_MUL, 8'h10, 8'h10);
    repeat (3) stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("abort.inReady", {31'd0, in_ready}, 32'd1);
    checkOutput("abort.busy", {31'd0, busy}, 32'd0);
    checkOutput("abort.outR", {24'd0, out_r}, 32'd0);
    sawValid = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) sawValid++;
      stepCycle();
    end
    checkOutput("abort.noValid", sawValid, 0);

    // rst and in_valid together: the op must not be taken.
    in_op    = OP_ADD;
    in_a     = 8'h01;
    in_b     = 8'h01;
    in_valid = 1'b1;
    rst      = 1'b1;
    stepCycle();
    rst      = 1'b0;
    in_valid = 1'b0;
    checkOutput("rstAccept.valid", {31'd0, out_valid}, 32'd0);
    stepCycle();
    checkOutput("rstAccept.valid2", {31'd0, out_valid}, 32'd0);
    checkOutput("rstAccept.outR", {24'd0, out_r}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
